// File: rtl/popcount_window_sum.sv
// Sliding-window sum of ones-counts over the last DEPTH accepted samples.
// Optional peak tracking is built when COUNT_WINDOW_PEAK_EN is defined.
module popcount_window_sum #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [2:0]       count,
  input  logic             clear,
  output logic [PTR_W+2:0] win_sum,
  output logic             win_full,
  output logic             out_valid,
  output logic             overrange,
  output logic [PTR_W+2:0] peak_sum
);
  localparam int SW = PTR_W + 3;

  typedef enum logic {FILL, STEADY} state_t;

  state_t                  state_q, state_d;
  logic [DEPTH-1:0][2:0]   smp_buf;
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        fill_q;
  logic                    accept;
  logic [2:0]              cnt;
  logic [2:0]              old;
  logic [SW-1:0]           sum_nxt;

  assign accept  = in_valid & ~clear;
  assign cnt     = (count > 3'd4) ? 3'd4 : count;
  // FILL masks evictions, so stale buffer contents after clear are harmless
  assign old     = (state_q == STEADY) ? smp_buf[wr_ptr] : 3'd0;
  assign sum_nxt = win_sum + SW'(cnt) - SW'(old);

  always_comb begin
    state_d = state_q;
    if (clear)
      state_d = FILL;
    else if (accept && state_q == FILL && fill_q == PTR_W'(DEPTH - 1))
      state_d = STEADY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      fill_q    <= '0;
      wr_ptr    <= '0;
      win_sum   <= '0;
      win_full  <= 1'b0;
      out_valid <= 1'b0;
      overrange <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_valid <= accept;
      if (clear) begin
        fill_q   <= '0;
        wr_ptr   <= '0;
        win_sum  <= '0;
        win_full <= 1'b0;
      end else if (in_valid) begin
        wr_ptr   <= wr_ptr + 1'b1;
        win_sum  <= sum_nxt;
        win_full <= (state_d == STEADY);
        if (state_q == FILL) fill_q <= fill_q + 1'b1;
        if (count > 3'd4) overrange <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) smp_buf[wr_ptr] <= cnt;
  end

`ifdef COUNT_WINDOW_PEAK_EN
  logic [SW-1:0] peak_q;

  always_ff @(posedge clk) begin
    if (rst || clear)
      peak_q <= '0;
    else if (in_valid && sum_nxt > peak_q)
      peak_q <= sum_nxt;
  end

  assign peak_sum = peak_q;
`else
  assign peak_sum = '0;
`endif

endmodule

// File: doc/popcount_window_sum.md
# popcount_window_sum

Downstream consumer of the four-input ones-count stage. It accepts one 3-bit count (0..4) per valid cycle and keeps a sliding-window sum over the last DEPTH accepted samples. The sum, a window-full flag and an error flag are presented to the next stage as registered outputs. The block holds a circular sample buffer, a fill counter and a two-state fill/steady controller.

## Interface
- DEPTH, 8: window length in accepted samples; power of two, 2..64.
- PTR_W, 3: log2(DEPTH); buffer pointer width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  count is a sample this cycle.
- count  in  3  ones-count from the upstream stage; legal range 0..4.
- clear  in  1  synchronous window flush; does not clear overrange.
- win_sum  out  PTR_W+3  sum of the last min(accepted, DEPTH) samples.
- win_full  out  1  DEPTH samples accepted since the last rst or clear.
- out_valid  out  1  one-cycle pulse after each accepted sample.
- overrange  out  1  sticky flag: an input count greater than 4 was accepted.
- peak_sum  out  PTR_W+3  maximum win_sum since the last rst or clear (see Configuration).

## Operation
- Accept condition: in_valid=1 and clear=0 and rst=0.
- Arithmetic count: cnt = (count>4) ? 4 : count. An accepted count>4 sets overrange, which stays set until rst.
- Evicted sample: old = buf[wr_ptr] in STEADY, 0 in FILL.
- Sum update: win_sum <= win_sum + cnt - old. The width PTR_W+3 holds 4*DEPTH exactly, so the sum never wraps and never underflows.
- Buffer write: buf[wr_ptr] <= cnt; wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
- FSM states:
  - FILL (reset state): fill counter increments per accepted sample. The accept that brings the fill count to DEPTH moves the FSM to STEADY and sets win_full.
  - STEADY: each accept evicts the oldest sample; win_full stays 1.
  - clear moves either state to FILL.
- Idle cycle (in_valid=0): all state holds and out_valid=0.
- clear=1: win_sum, wr_ptr, fill count, win_full and peak_sum go to 0 and the FSM goes to FILL. A sample presented in the same cycle is dropped. Buffer contents need not be zeroed, because FILL masks evictions.
- rst=1 does everything clear does, plus overrange=0 and out_valid=0. rst has priority over clear and in_valid.
- rst or clear in mid-window discards the partial window. The next accepted sample starts a new window at win_sum=cnt.

## Timing
- Reset value of every output is 0: win_sum, win_full, out_valid, overrange, peak_sum.
- All outputs are registered; there is no combinational path from input to output.
- Latency 1: the edge that accepts a sample updates win_sum, win_full, overrange and peak_sum. out_valid is 1 for exactly the following cycle.
- Back-to-back accepts are supported every cycle, giving full throughput.
- Downstream has no backpressure. Each out_valid pulse must be consumed by the next stage in the cycle it appears.

## Configuration
- COUNT_WINDOW_PEAK_EN defined:
  - peak_sum <= max(peak_sum, new win_sum) on every accepted sample.
  - peak_sum is zeroed by rst and by clear.
- COUNT_WINDOW_PEAK_EN undefined:
  - the peak register and comparator are not built.
  - the peak_sum port remains and is tied to 0.

## Test plan
- Reset: hold rst 2 cycles with in_valid=1 and count=4 -> all outputs 0, FSM in FILL.
- Fill (DEPTH=8): 8 consecutive accepts of count=4 -> win_sum 4,8,…,32. win_full rises on the 8th accept edge, and out_valid pulses each following cycle.
- Eviction: after the fill, 3 accepts of count=0 -> win_sum 28,24,20 and win_full stays 1. With the macro, peak_sum holds at 32.
- Gaps: alternate in_valid 1/0 with count=2 -> win_sum steps only on valid cycles and out_valid is never high for two consecutive cycles.
- Overrange: accept count=7 from reset -> win_sum=4, overrange=1.
  - overrange stays 1 through a subsequent clear.
  - overrange returns to 0 only on rst.
- Clear collision: in STEADY with win_sum=20, drive clear=1, in_valid=1 and count=3 -> win_sum=0, win_full=0 and peak_sum=0. The next accept of 3 gives win_sum=3.
